// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accumulator machine that feeds an external combinational ALU,
// waits a settle time, captures its result/flags and returns them over a valid/ready port.
module alu_cmd_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [3:0] cmd_s_amt,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_s_amt,
    output logic [2:0] alu_control,
    input  logic [7:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic [7:0] acc,
    output logic [3:0] flags,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [3:0] rsp_flags
);
    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic       accept;
    logic [7:0] ld_val;
    logic [3:0] ld_flags;

    assign rsp_valid = (state == RESP);
    assign accept    = (state == IDLE) && cmd_valid && cmd_ready;

    always_comb begin
        state_nx = state;
        ld_val   = cmd_mode[0] ? 8'd0 : cmd_b;
        ld_flags = cmd_mode[0] ? 4'b0010 : {1'b0, cmd_b[7], cmd_b == 8'd0, 1'b0};
        unique case (state)
            IDLE:    if (accept) state_nx = cmd_mode[1] ? RESP : DRIVE;
            DRIVE:   if (cnt == 4'd0) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // cmd_ready is registered so it reads 0 during reset and rises on the first clock after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            cnt         <= 4'd0;
            alu_a       <= 8'd0;
            alu_b       <= 8'd0;
            alu_s_amt   <= 4'd0;
            alu_control <= 3'd0;
            acc         <= 8'd0;
            flags       <= 4'd0;
            rsp_data    <= 8'd0;
            rsp_flags   <= 4'd0;
        end else begin
            state     <= state_nx;
            cmd_ready <= (state_nx == IDLE);
            if (accept && !cmd_mode[1]) begin
                alu_a       <= cmd_mode[0] ? cmd_a : acc;
                alu_b       <= cmd_b;
                alu_s_amt   <= cmd_s_amt;
                alu_control <= cmd_op;
                cnt         <= 4'(SETTLE_CYCLES - 1);
            end
            if (accept && cmd_mode[1]) begin
                acc       <= ld_val;
                flags     <= ld_flags;
                rsp_data  <= ld_val;
                rsp_flags <= ld_flags;
            end
            if (state == DRIVE && cnt == 4'd0) begin
                acc       <= alu_result;
                flags     <= alu_flags;
                rsp_data  <= alu_result;
                rsp_flags <= alu_flags;
            end else if (state == DRIVE) begin
                cnt <= cnt - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: transaction-level model of the sequencer driving a bench ALU,
// plus a second instance (SETTLE_CYCLES=4) for the asynchronous abort case.
module tb_alu_cmd_sequencer;
    localparam int S1 = 1;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0, rst4 = 1'b0;
    logic       cmd_valid = 1'b0, cv4 = 1'b0, rsp_ready = 1'b0, rr4 = 1'b0;
    logic [1:0] cmd_mode = '0;
    logic [2:0] cmd_op = '0;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic [3:0] cmd_s_amt = '0;

    logic       rdy1, rv1, rdy4, rv4;
    logic [7:0] aa1, ab1, ar1, acc1, rd1, aa4, ab4, ar4, acc4, rd4;
    logic [3:0] as1, af1, fl1, rf1, as4, af4, fl4, rf4;
    logic [2:0] ac1, ac4;

    int checks = 0, failures = 0;
    logic       chk_en = 1'b0;
    logic       exp_rdy, exp_rv;
    logic [7:0] exp_acc, exp_aa, exp_ab, exp_rd;
    logic [3:0] exp_fl, exp_as, exp_rf;
    logic [2:0] exp_ac;
    logic [7:0] last_aa, last_ab, last_rd;
    logic [3:0] last_as, last_rf;

    // Bench ALU: 000 add, 001 sub (C = no borrow), 010 and, 011 or, 100 (a+b)<<s, 101 xor, 110 a>>s, 111 not a
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic [3:0] s);
        logic [8:0] w;
        logic [7:0] r;
        logic v, c;
        v = 1'b0;
        c = 1'b0;
        w = '0;
        case (op)
            3'd0: begin w = a + b; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            3'd1: begin r = a - b; c = (a >= b); v = (a[7] != b[7]) && (r[7] != a[7]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = 8'(a + b) << s;
            3'd5: r = a ^ b;
            3'd6: r = a >> s;
            default: r = ~a;
        endcase
        return {v, r[7], r == 8'd0, c, r};
    endfunction

    assign {af1, ar1} = alu_fn(aa1, ab1, ac1, as1);
    assign {af4, ar4} = alu_fn(aa4, ab4, ac4, as4);

    alu_cmd_sequencer #(.SETTLE_CYCLES(S1)) d1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy1), .cmd_mode(cmd_mode),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s_amt(cmd_s_amt), .alu_a(aa1), .alu_b(ab1),
        .alu_s_amt(as1), .alu_control(ac1), .alu_result(ar1), .alu_flags(af1), .acc(acc1), .flags(fl1),
        .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_data(rd1), .rsp_flags(rf1));

    alu_cmd_sequencer #(.SETTLE_CYCLES(4)) d4 (
        .clk(clk), .rst_n(rst4), .cmd_valid(cv4), .cmd_ready(rdy4), .cmd_mode(cmd_mode),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s_amt(cmd_s_amt), .alu_a(aa4), .alu_b(ab4),
        .alu_s_amt(as4), .alu_control(ac4), .alu_result(ar4), .alu_flags(af4), .acc(acc4), .flags(fl4),
        .rsp_valid(rv4), .rsp_ready(rr4), .rsp_data(rd4), .rsp_flags(rf4));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", rdy1, exp_rdy);
            chk("rsp_valid", rv1, exp_rv);
            chk("acc", acc1, exp_acc);
            chk("flags", fl1, exp_fl);
            chk("alu_a", aa1, exp_aa);
            chk("alu_b", ab1, exp_ab);
            chk("alu_s_amt", as1, exp_as);
            chk("alu_control", ac1, exp_ac);
            if (exp_rv) begin
                chk("rsp_data", rd1, exp_rd);
                chk("rsp_flags", rf1, exp_rf);
            end
        end
    end

    task automatic scramble();
        cmd_valid = 1'($urandom);
        cmd_mode  = 2'($urandom);
        cmd_op    = 3'($urandom);
        cmd_a     = 8'($urandom);
        cmd_b     = 8'($urandom);
        cmd_s_amt = 4'($urandom);
    endtask

    // One transaction: accept, wait the settle time, hold the response for 'hold' cycles, then hand it off
    task automatic run_cmd(input logic [1:0] m, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] s, input int hold);
        logic [11:0] res;
        cmd_valid = 1'b1; cmd_mode = m; cmd_op = op; cmd_a = a; cmd_b = b; cmd_s_amt = s;
        rsp_ready = 1'($urandom);
        @(posedge clk); #1;
        exp_rdy = 1'b0;
        if (m[1]) begin
            res = m[0] ? 12'h200 : {1'b0, b[7], b == 8'd0, 1'b0, b};
        end else begin
            res = alu_fn(m[0] ? a : exp_acc, b, op, s);
            exp_aa = m[0] ? a : exp_acc; exp_ab = b; exp_as = s; exp_ac = op;
            last_aa = aa1; last_ab = ab1; last_as = as1;
            for (int i = 0; i < S1; i++) begin
                scramble();
                rsp_ready = 1'($urandom);
                @(posedge clk); #1;
            end
        end
        exp_acc = res[7:0]; exp_fl = res[11:8]; exp_rd = res[7:0]; exp_rf = res[11:8]; exp_rv = 1'b1;
        last_rd = rd1; last_rf = rf1;
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            scramble();
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        scramble();
        @(posedge clk); #1;
        exp_rv = 1'b0; exp_rdy = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset cmd_ready", rdy1, 0);
        chk("reset rsp_valid", rv1, 0);
        chk("reset acc/flags", {acc1, fl1}, 0);
        chk("reset alu", {aa1, ab1, as1, ac1}, 0);
        chk("reset rsp", {rd1, rf1}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("cmd_ready after reset", rdy1, 1);
        exp_rdy = 1'b1; exp_rv = 1'b0; exp_acc = '0; exp_fl = '0; exp_aa = '0; exp_ab = '0;
        exp_as = '0; exp_ac = '0; exp_rd = '0; exp_rf = '0;
        chk_en = 1'b1;

        run_cmd(2'b10, 3'd0, 8'h00, 8'h05, 4'd0, 0);
        run_cmd(2'b00, 3'd0, 8'h00, 8'h03, 4'd0, 0);
        chk("add data", last_rd, 8'h08);
        chk("add flags", last_rf, 4'b0000);
        chk("add acc", acc1, 8'h08);
        run_cmd(2'b10, 3'd0, 8'h00, 8'h03, 4'd0, 1);
        run_cmd(2'b00, 3'd1, 8'h00, 8'h03, 4'd0, 0);
        chk("sub data", last_rd, 8'h00);
        chk("sub flags", last_rf, 4'b0011);
        run_cmd(2'b10, 3'd0, 8'h00, 8'h7F, 4'd0, 0);
        chk("load 7f flags", last_rf, 4'b0000);
        run_cmd(2'b00, 3'd0, 8'h00, 8'h01, 4'd0, 2);
        chk("ovf data", last_rd, 8'h80);
        chk("ovf flags", last_rf, 4'b1100);
        run_cmd(2'b01, 3'd4, 8'h01, 8'h01, 4'd2, 0);
        chk("imm alu_a", last_aa, 8'h01);
        chk("imm alu_b", last_ab, 8'h01);
        chk("imm alu_s_amt", last_as, 4'd2);
        chk("shift data", last_rd, 8'h08);
        run_cmd(2'b11, 3'd0, 8'h00, 8'h55, 4'd0, 3);
        chk("clear acc", acc1, 8'h00);
        chk("clear flags", fl1, 4'b0010);

        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run_cmd(2'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
        end

        // Abort mid-DRIVE on the slow instance
        cmd_mode = 2'b00; cmd_op = 3'd0; cmd_b = 8'h12; cmd_s_amt = 4'd0;
        rst4 = 1'b1;
        @(posedge clk); #1;
        chk("d4 cmd_ready after reset", rdy4, 1);
        cv4 = 1'b1;
        @(posedge clk); #1;
        cv4 = 1'b0;
        @(posedge clk); #1;
        chk("d4 rsp_valid in drive", rv4, 0);
        chk("d4 alu_b in drive", ab4, 8'h12);
        #2 rst4 = 1'b0;
        #1;
        chk("d4 abort ready/valid", {rdy4, rv4}, 0);
        chk("d4 abort alu", {aa4, ab4, as4, ac4}, 0);
        chk("d4 abort acc/flags/rsp", {acc4, fl4, rd4, rf4}, 0);
        repeat (5) begin
            @(posedge clk); #1;
            chk("d4 no rsp in reset", rv4, 0);
        end
        rst4 = 1'b1;
        @(posedge clk); #1;
        chk("d4 ready after release", rdy4, 1);
        chk("d4 no rsp after release", rv4, 0);
        chk("d4 acc after release", acc4, 0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator side of the 8-bit ALU operand/result interface. It accepts commands over a valid/ready port and owns an 8-bit accumulator. For each command it drives registered operands, s_amt and control into the ALU, waits a fixed settle time, and captures RESULT plus the four flags. It then returns the result and flags over a valid/ready response port. It sits between the pad/io glue and the combinational ALU, turning the ALU into a multi-op accumulator machine.

Parameters:
SETTLE_CYCLES, 1, cycles ALU inputs are held before RESULT/flags are sampled; legal range 1..15.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  sequencer can accept a command
cmd_mode  input  2  00 ALU op with A=acc; 01 ALU op with A=cmd_a; 10 load acc=cmd_b; 11 clear acc
cmd_op  input  3  ALU control code passed to alu_control
cmd_a  input  8  immediate A operand (mode 01 only)
cmd_b  input  8  B operand, or load value in mode 10
cmd_s_amt  input  4  shift amount passed to alu_s_amt
alu_a  output  8  ALU A operand
alu_b  output  8  ALU B operand
alu_s_amt  output  4  ALU shift amount
alu_control  output  3  ALU operation select
alu_result  input  8  ALU RESULT
alu_flags  input  4  {OVERFLOW, NEGATIVE, ZERO, CARRY} from ALU
acc  output  8  accumulator
flags  output  4  last captured {V,N,Z,C}
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_data  output  8  result of the completed command
rsp_flags  output  4  flags of the completed command

Behaviour:
- Reset: all outputs are 0 and state is IDLE, including acc, flags, alu_*, rsp_* and cmd_ready. rst_n low at any time, including mid-command, aborts immediately; no response is issued for the aborted command.
- States: IDLE, DRIVE, RESP. cmd_ready=1 only in IDLE. rsp_valid=1 only in RESP.
- IDLE: on cmd_valid&cmd_ready the command is accepted at that edge.
  - Mode 00/01: at that edge, alu_a<=acc (00) or cmd_a (01); alu_b<=cmd_b; alu_s_amt<=cmd_s_amt; alu_control<=cmd_op; settle counter<=SETTLE_CYCLES-1. Go to DRIVE.
  - Mode 10: acc<=cmd_b; flags<={0, cmd_b[7], cmd_b==0, 0}. Go to RESP.
  - Mode 11: acc<=0; flags<=4'b0010. Go to RESP.
- DRIVE: alu_* outputs are stable. When the counter is 0, sample at that edge: acc<=alu_result, flags<=alu_flags, rsp_data<=alu_result, rsp_flags<=alu_flags. Go to RESP. Otherwise decrement the counter.
- Latency with SETTLE_CYCLES=1: accept at edge N, sample and rsp_valid high at edge N+1. With rsp_ready=1, return to IDLE at N+2, so one command completes per 3 cycles. General case: rsp_valid high at edge N+SETTLE_CYCLES.
- Modes 10/11: rsp_valid high at edge N+1; rsp_data=new acc; rsp_flags=new flags.
- RESP: rsp_data, rsp_flags, acc and flags are held stable while rsp_valid=1 and rsp_ready=0. On rsp_valid&rsp_ready, go to IDLE at that edge.
- alu_* hold their last driven value outside DRIVE; they change only on command acceptance.
- cmd_* inputs are ignored outside IDLE; changing them during DRIVE has no effect.
- Arithmetic: all widths are 8 bits; wrap-around comes from the ALU. No sequencer-side arithmetic except the zero/negative flags for load.

Test Plan:
- Reset, then mode 10 load b=0x05, then mode 00 op=000 (ADD) b=0x03 -> rsp_data=0x08, rsp_flags=0000, acc=0x08; rsp_valid exactly 1 cycle after ADD acceptance.
- Load 0x03, then mode 00 op=001 (SUB) b=0x03 -> rsp_data=0x00, rsp_flags=0011 (Z=1, C=1).
- Load 0x7F, then ADD b=0x01 -> rsp_data=0x80, rsp_flags=1100 (V=1, N=1).
- Mode 01 cmd_a=0x01, op=100, b=0x01, s_amt=2 -> alu_a=0x01, alu_b=0x01, alu_s_amt=2 during DRIVE; rsp_data=0x08. Also check mode 11 -> acc=0x00, flags=0010.
- Hold rsp_ready=0 for 3 cycles -> rsp_valid, rsp_data and acc stable, cmd_ready=0; a toggling cmd_valid is ignored. Release -> IDLE next edge.
- Assert rst_n low during DRIVE with SETTLE_CYCLES=4 -> all outputs 0 immediately (asynchronous). No rsp_valid. After release, cmd_ready=1 on the first clock.
